// File: rtl/mips_boot_loader.sv
// mips_boot_loader: streams a program image into MIPS instruction memory over
// a byte valid/ready link and holds the core in reset until the image is in.
// Frame: LEN_HI, LEN_LO (N words), 4*N big-endian data bytes[, checksum].
// Optional feature macro: BOOT_CHECKSUM_EN adds the trailing XOR checksum byte.
// Handshake: a byte moves on a rising clk edge only when in_valid && in_ready;
// in_ready depends on state alone, so in_valid may come and go freely.
module mips_boot_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0]     MAX_N  = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WL_ONE = (ADDR_W + 1)'(1);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERROR
  } state_t;
`endif

  state_t      state;
  logic [15:0] len;
  logic [23:0] word_sr;    // first three bytes of the word being assembled
  logic [1:0]  byte_idx;   // byte position inside the current word
  logic        xfer;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  acc;        // XOR of data bytes only
`endif

  assign xfer = in_valid && in_ready;

  // Ready is a pure function of state: open in header, data and checksum phases.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      S_CHECK:                    in_ready = 1'b1;
`endif
      default:                    in_ready = 1'b0;
    endcase
  end

  // Loader FSM with registered outputs; imem_we is a one-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      len          <= '0;
      word_sr      <= '0;
      byte_idx     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
      acc          <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_LEN_HI;
            words_loaded <= '0;
            byte_idx     <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            acc          <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= in_data;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= in_data;
            if ({1'b0, len[15:8], in_data} > MAX_N) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else if ({len[15:8], in_data} == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
              state    <= S_CHECK;
`else
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            word_sr  <= {word_sr[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            acc      <= acc ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= {word_sr, in_data};
              words_loaded <= words_loaded + WL_ONE;
              if (16'(words_loaded) + 16'd1 == len) begin
`ifdef BOOT_CHECKSUM_EN
                state    <= S_CHECK;
`else
                state    <= S_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            if (in_data == acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Testbench for mips_boot_loader: directed frame table, random frames scored
// against a frame-level model, and hand sequences for reset and spurious start.
// Works with or without BOOT_CHECKSUM_EN defined.
module tb_mips_boot_loader;

  localparam int ADDR_W = 6;
  localparam int MAXW   = 1 << ADDR_W;
  localparam int W      = ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk = ~clk;

  mips_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  frame_w[MAXW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Every IMEM write must match the next expected {addr, word}; ready must be
  // closed whenever the loader reports done or error.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h required=none @%0t",
                 {imem_addr, imem_wdata}, $time);
      end else begin
        check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
    end
    if (done || error) check("in_ready_closed", in_ready, 1'b0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] frame_xor(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++)
      x ^= frame_w[i][31:24] ^ frame_w[i][23:16] ^ frame_w[i][15:8] ^ frame_w[i][7:0];
    return x;
  endfunction

  task automatic model_outcome(input int n, input logic [7:0] chk,
                               output logic m_done, output logic m_err);
    if (n > MAXW) begin
      m_done = 1'b0; m_err = 1'b1;
    end else begin
`ifdef BOOT_CHECKSUM_EN
      m_done = (chk == frame_xor(n));
`else
      m_done = 1'b1;
`endif
      m_err = !m_done;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called and returning on a negative edge; the byte has moved on return.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int waited;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout actual=in_ready0 required=in_ready1 @%0t", $time);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int n, input logic [7:0] chk,
                           input int gap_max, input logic e_done, input logic e_err,
                           input int e_words);
    logic [15:0] nn;
    logic [ADDR_W-1:0] a;
    nn = 16'(n);
    if (n <= MAXW)
      for (int i = 0; i < n; i++) begin
        a = i[ADDR_W-1:0];
        exp_q.push_back({a, frame_w[i]});
      end
    pulse_start();
    check({tag, "_hold_at_start"}, {cpu_hold, done, error, in_ready}, 4'b1001);
    check({tag, "_words_at_start"}, 64'(words_loaded), 64'd0);
    send_byte(nn[15:8], gap_max);
    send_byte(nn[7:0], gap_max);
    if (n <= MAXW) begin
      for (int i = 0; i < n; i++)
        for (int k = 3; k >= 0; k--)
          send_byte(frame_w[i][8*k +: 8], gap_max);
`ifdef BOOT_CHECKSUM_EN
      send_byte(chk, gap_max);
`endif
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_done"}, done, e_done);
    check({tag, "_error"}, error, e_err);
    check({tag, "_cpu_hold"}, cpu_hold, !e_done);
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'(e_words));
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_writes_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  chk;
    int          gap_max;
    logic        exp_done;
    logic        exp_err;
    int          exp_words;
  } vec_t;

  vec_t tab[8];

  initial begin
    logic m_done, m_err;
    int   n;
    logic [7:0] chk;

`ifdef BOOT_CHECKSUM_EN
    tab[0] = '{2, 32'h8C010000, 32'hAC020004, 8'h27, 0, 1'b1, 1'b0, 2};
    tab[1] = '{2, 32'h8C010000, 32'hAC020004, 8'h26, 0, 1'b0, 1'b1, 2};
    tab[7] = '{0, 32'h0,        32'h0,        8'h5A, 0, 1'b0, 1'b1, 0};
`else
    tab[0] = '{2, 32'h8C010000, 32'hAC020004, 8'h27, 0, 1'b1, 1'b0, 2};
    tab[1] = '{2, 32'h8C010000, 32'hAC020004, 8'h26, 0, 1'b1, 1'b0, 2};
    tab[7] = '{0, 32'h0,        32'h0,        8'h5A, 0, 1'b1, 1'b0, 0};
`endif
    tab[2] = '{2,       32'h8C010000, 32'hAC020004, 8'h27, 0, 1'b1, 1'b0, 2};
    tab[3] = '{16'h0041, 32'h0,       32'h0,        8'h00, 0, 1'b0, 1'b1, 0};
    tab[4] = '{0,       32'h0,        32'h0,        8'h00, 0, 1'b1, 1'b0, 0};
    tab[5] = '{16'h1000, 32'h0,       32'h0,        8'h00, 0, 1'b0, 1'b1, 0};
    tab[6] = '{2,       32'h8C010000, 32'hAC020004, 8'h27, 5, 1'b1, 1'b0, 2};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_ctrl", {in_ready, imem_we, cpu_hold, done, error}, 5'b00100);
    check("rst_addr_data", {imem_addr, imem_wdata}, 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ctrl", {in_ready, imem_we, cpu_hold, done, error}, 5'b00100);

    for (int t = 0; t < 8; t++) begin
      frame_w[0] = tab[t].w0;
      frame_w[1] = tab[t].w1;
      run_frame($sformatf("vec%0d", t), tab[t].n, tab[t].chk, tab[t].gap_max,
                tab[t].exp_done, tab[t].exp_err, tab[t].exp_words);
    end

    // reset after 6 data bytes, with a spurious start mid-frame first
    frame_w[0] = 32'h8C010000;
    frame_w[1] = 32'hAC020004;
    exp_q.push_back({{ADDR_W{1'b0}}, frame_w[0]});
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h8C, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'hAC, 0); send_byte(8'h02, 0);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midload_start_ignored_words", 64'(words_loaded), 64'd1);
    check("midload_start_ignored_ready", in_ready, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ctrl", {in_ready, imem_we, cpu_hold, done, error}, 5'b00100);
    check("midrst_addr_data", {imem_addr, imem_wdata}, 64'd0);
    check("midrst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    check("midrst_writes_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    run_frame("after_rst", 2, 8'h27, 0, 1'b1, 1'b0, 2);

    // random frames against the model, including the full 2**ADDR_W image
    for (int r = 0; r < 6; r++) begin
      n = (r == 0) ? MAXW : int'($urandom_range(MAXW, 1));
      for (int i = 0; i < n; i++) frame_w[i] = $urandom;
      chk = frame_xor(n);
      if ($urandom_range(3, 0) == 0) chk ^= 8'(1 << $urandom_range(7, 0));
      model_outcome(n, chk, m_done, m_err);
      run_frame($sformatf("rnd%0d", r), n, chk, 3, m_done, m_err, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
